// File: rtl/nv_nvdla_cmac_core_mac_acc.sv
// CMAC MAC/accumulate slice: per-lane signed multiply, atom sum (stage A),
// group accumulate with optional saturation (stage B), then a retiming output pipe.
module nv_nvdla_cmac_core_mac_acc #(
  parameter int CMAC_ATOMC        = 8,
  parameter int CMAC_BPE          = 8,
  parameter int ACC_WIDTH         = 32,
  parameter int CMAC_OUT_RETIMING = 2
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  input  logic                           cfg_reg_en,
  input  logic [7:0]                     cfg_acc_len,
  input  logic                           cfg_sat_en,
  input  logic [CMAC_ATOMC*CMAC_BPE-1:0] dat_actv_data,
  input  logic [CMAC_ATOMC*CMAC_BPE-1:0] wt_actv_data,
  input  logic [CMAC_ATOMC-1:0]          dat_actv_nz,
  input  logic [CMAC_ATOMC-1:0]          wt_actv_nz,
  input  logic [CMAC_ATOMC-1:0]          dat_actv_pvld,
  input  logic [CMAC_ATOMC-1:0]          wt_actv_pvld,
  output logic [ACC_WIDTH-1:0]           mac_out_data,
  output logic                           mac_out_pvld,
  output logic                           mac_out_sat
);

  localparam int PROD_W = 2 * CMAC_BPE;
  localparam int SUM_W  = PROD_W + $clog2(CMAC_ATOMC);
  localparam int NSTG   = CMAC_OUT_RETIMING + 1;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [PROD_W-1:0]    w_prod [CMAC_ATOMC];
  logic signed [SUM_W-1:0]     w_atomSum;
  logic                        w_atomVld;
  logic [7:0]                  w_accLenEff;
  logic                        w_satEnEff;
  logic [7:0]                  w_cntEff;
  logic                        w_first;
  logic                        w_last;
  logic signed [ACC_WIDTH:0]   w_accWide;
  logic                        w_ovf;
  logic signed [ACC_WIDTH-1:0] w_accNext;
  logic                        w_satNext;

  logic [7:0]                  r_accLen;
  logic                        r_satEn;
  logic [7:0]                  r_cnt;
  logic                        r_vldA;
  logic signed [SUM_W-1:0]     r_sumA;
  logic                        r_firstA;
  logic                        r_lastA;
  logic                        r_satEnA;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_sat;
  logic                        r_pipeVld  [NSTG];
  logic [ACC_WIDTH-1:0]        r_pipeData [NSTG];
  logic                        r_pipeSat  [NSTG];

  // Lanes missing either valid or either nonzero flag contribute nothing.
  always_comb begin
    w_atomSum = '0;
    for (int i = 0; i < CMAC_ATOMC; i++) begin
      w_prod[i] = '0;
      if (wt_actv_pvld[i] & dat_actv_pvld[i] & wt_actv_nz[i] & dat_actv_nz[i])
        w_prod[i] = PROD_W'($signed(wt_actv_data[i*CMAC_BPE +: CMAC_BPE]))
                  * PROD_W'($signed(dat_actv_data[i*CMAC_BPE +: CMAC_BPE]));
      w_atomSum = w_atomSum + SUM_W'(w_prod[i]);
    end
  end

  // A config strobe takes effect for an atom arriving in the same cycle.
  assign w_atomVld   = dat_actv_pvld[0] & wt_actv_pvld[0];
  assign w_accLenEff = cfg_reg_en ? cfg_acc_len : r_accLen;
  assign w_satEnEff  = cfg_reg_en ? cfg_sat_en  : r_satEn;
  assign w_cntEff    = cfg_reg_en ? 8'd0        : r_cnt;
  assign w_first     = (w_cntEff == 8'd0);
  assign w_last      = (w_cntEff == w_accLenEff);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_accLen <= 8'd0;
      r_satEn  <= 1'b0;
      r_cnt    <= 8'd0;
      r_vldA   <= 1'b0;
      r_sumA   <= '0;
      r_firstA <= 1'b0;
      r_lastA  <= 1'b0;
      r_satEnA <= 1'b0;
    end else begin
      if (cfg_reg_en) begin
        r_accLen <= cfg_acc_len;
        r_satEn  <= cfg_sat_en;
      end
      if (w_atomVld)
        r_cnt <= w_last ? 8'd0 : w_cntEff + 8'd1;
      else if (cfg_reg_en)
        r_cnt <= 8'd0;
      r_vldA <= w_atomVld;
      if (w_atomVld) begin
        r_sumA   <= w_atomSum;
        r_firstA <= w_first;
        r_lastA  <= w_last;
        r_satEnA <= w_satEnEff;
      end
    end
  end

  // One extra bit of headroom exposes signed overflow as a top-bit disagreement.
  assign w_accWide = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(r_sumA);
  assign w_ovf     = w_accWide[ACC_WIDTH] ^ w_accWide[ACC_WIDTH-1];

  always_comb begin
    w_accNext = w_accWide[ACC_WIDTH-1:0];
    w_satNext = r_sat;
    if (r_firstA) begin
      w_accNext = ACC_WIDTH'(r_sumA);
      w_satNext = 1'b0;
    end else if (w_ovf && r_satEnA) begin
      w_accNext = w_accWide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      w_satNext = 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        r_pipeVld[k]  <= 1'b0;
        r_pipeData[k] <= '0;
        r_pipeSat[k]  <= 1'b0;
      end
    end else begin
      if (r_vldA) begin
        r_acc <= w_accNext;
        r_sat <= w_satNext;
      end
      r_pipeVld[0] <= r_vldA & r_lastA;
      if (r_vldA & r_lastA) begin
        r_pipeData[0] <= w_accNext;
        r_pipeSat[0]  <= w_satNext;
      end
      // Data stages only move with a valid so the outputs hold the last result.
      for (int k = 1; k < NSTG; k++) begin
        r_pipeVld[k] <= r_pipeVld[k-1];
        if (r_pipeVld[k-1]) begin
          r_pipeData[k] <= r_pipeData[k-1];
          r_pipeSat[k]  <= r_pipeSat[k-1];
        end
      end
    end
  end

  assign mac_out_data = r_pipeData[CMAC_OUT_RETIMING];
  assign mac_out_pvld = r_pipeVld[CMAC_OUT_RETIMING];
  assign mac_out_sat  = r_pipeSat[CMAC_OUT_RETIMING];

endmodule
